// File: rtl/proc_pkg.sv
// Shared constants and helpers for the processor register bank.
package proc_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 4;
  localparam int ZERO_REG_DEF = 0;
  localparam int MON_IDX_DEF  = 15;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Bus bundle for the register bank: read ports, write port, allocate port and status.
interface regfile_bypass_sb_if
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
);

  logic                           rd_en;
  logic [NUM_RD*ADDR_W-1:0]       rd_addr;
  logic [NUM_RD*DATA_W-1:0]       rd_data;
  logic [NUM_RD-1:0]              rd_busy;
  logic                           wr_en;
  logic [ADDR_W-1:0]              wr_addr;
  logic [DATA_W-1:0]              wr_data;
  logic [be_width(DATA_W)-1:0]    wr_be;
  logic                           alloc_en;
  logic [ADDR_W-1:0]              alloc_addr;
  logic [(2**ADDR_W)-1:0]         busy_vec;
  logic [DATA_W-1:0]              mon_reg;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be, alloc_en, alloc_addr,
    input  rd_data, rd_busy, busy_vec, mon_reg
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be, alloc_en, alloc_addr,
    output rd_data, rd_busy, busy_vec, mon_reg
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with registered per-port lookup.
module regfile_scoreboard #(
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_en_i,
  input  logic [ADDR_W-1:0]          alloc_addr_i,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic                       rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [(2**ADDR_W)-1:0]     busy_vec_o,
  output logic [NUM_RD-1:0]          rd_busy_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [NUM_RD-1:0] rd_busy_q, rd_busy_d;

  // Allocate is applied after the clear so a same-cycle new owner keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
    if (alloc_en_i) busy_d[alloc_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_comb begin
    rd_busy_d = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy_d[k] = busy_d[rd_addr_i[k*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      rd_busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (rd_en_i) rd_busy_q <= rd_busy_d;
    end
  end

  assign busy_vec_o = busy_q;
  assign rd_busy_o  = rd_busy_q;

endmodule

// File: rtl/regfile_bypass_sb.sv
// Parametrised register bank: byte-enabled writes, registered reads with
// same-cycle write forwarding, optional zero register and pending-write scoreboard.
module regfile_bypass_sb
  import proc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int MON_IDX  = MON_IDX_DEF
) (
  input logic                clk,
  input logic                rst_n,
  regfile_bypass_sb_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int BE_W  = be_width(DATA_W);
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DATA_W-1:0]        wr_merged;
  logic                     wr_commit;
  logic [ADDR_W-1:0]        rd_addr_k [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    wr_merged = regs_q[bus.wr_addr];
    for (int i = 0; i < BE_W; i++) begin
      if (bus.wr_be[i]) wr_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
    end
  end

  assign wr_commit = bus.wr_en && !(ZR && (bus.wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) regs_q[a] <= '0;
    end else if (wr_commit) begin
      regs_q[bus.wr_addr] <= wr_merged;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_addr
    assign rd_addr_k[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
  end

  // A read of the address being written sees the byte-merged value, not the stale one.
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (ZR && (rd_addr_k[k] == '0))
        rd_data_d[k*DATA_W +: DATA_W] = '0;
      else if (wr_commit && (rd_addr_k[k] == bus.wr_addr))
        rd_data_d[k*DATA_W +: DATA_W] = wr_merged;
      else
        rd_data_d[k*DATA_W +: DATA_W] = regs_q[rd_addr_k[k]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rd_data_q <= '0;
    else if (bus.rd_en)  rd_data_q <= rd_data_d;
  end

  assign bus.rd_data = rd_data_q;

  if (ZR && (MON_IDX == 0)) begin : g_mon_zero
    assign bus.mon_reg = '0;
  end else begin : g_mon_reg
    assign bus.mon_reg = regs_q[MON_IDX];
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_en_i   (bus.alloc_en),
    .alloc_addr_i (bus.alloc_addr),
    .wr_en_i      (bus.wr_en),
    .wr_addr_i    (bus.wr_addr),
    .rd_en_i      (bus.rd_en),
    .rd_addr_i    (bus.rd_addr),
    .busy_vec_o   (bus.busy_vec),
    .rd_busy_o    (bus.rd_busy)
  );

endmodule
